// File: rtl/resp_pack_pkg.sv
//-----------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Package   : resp_pkg                                                    |
// | Purpose   : Shared sizes and state encoding for the response packer.    |
// | Revision  : 1.0 - initial release                                       |
// +-------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
`default_nettype none

package resp_pkg;

   localparam int WORD_W     = 32;
   localparam int LINE_WORDS = 8;   // must be a power of two
   localparam int IDX_W      = 3;   // log2(LINE_WORDS)
   localparam int LINE_W     = WORD_W * LINE_WORDS;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      FULL = 2'b10
   } state_e;

endpackage

`default_nettype wire

// File: rtl/resp_pack_word_ins.sv
//-----------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module    : resp_word_ins                                               |
// | Purpose   : Combinational insertion of one word into a line at an index,|
// |             gated by a write enable. Other slots pass through.          |
// | Revision  : 1.0 - initial release                                       |
// +-------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
`default_nettype none

module resp_word_ins
   import resp_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic              we_i,
   output logic [LINE_W-1:0] line_o
);

   // One mux per slot: replace only the addressed slot when writing.
   for (genvar k = 0; k < LINE_WORDS; k++) begin : g_slot
      assign line_o[k*WORD_W +: WORD_W] =
         (we_i && (idx_i == IDX_W'(k))) ? word_i : line_i[k*WORD_W +: WORD_W];
   end

endmodule

`default_nettype wire

// File: rtl/resp_pack.sv
//-----------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module    : resp_pack                                                   |
// | Purpose   : Packs a stream of 32-bit response words into 256-bit lines  |
// |             with valid/ready handshakes on both sides. An early in_last |
// |             closes a short line; unfilled slots read zero.              |
// | Options   : RESP_PACK_STALL_CNT_EN adds a saturating 16-bit stall_cnt   |
// |             output counting cycles with out_vld && !out_rdy.            |
// | Revision  : 1.0 - initial release                                       |
// +-------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
`default_nettype none

module resp_pack
   import resp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [LINE_W-1:0] out_data,
`ifdef RESP_PACK_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic [IDX_W:0]    out_cnt
);

   state_e              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [LINE_W-1:0]   line_q;
   logic [LINE_W-1:0]   line_d;
   logic                out_vld_q;
   logic [IDX_W:0]      out_cnt_q;
   logic                w_xfer;
   logic                w_close;

   // A held line blocks the input; there is no bypass while FULL drains.
   assign in_rdy  = (state_q != FULL) && !rst;
   assign w_xfer  = in_vld && in_rdy;
   assign w_close = (idx_q == IDX_W'(LINE_WORDS - 1)) || in_last;

   resp_word_ins u_ins (
      .line_i (line_q),
      .word_i (in_data),
      .idx_i  (idx_q),
      .we_i   (w_xfer),
      .line_o (line_d)
   );

   // Fill/hold/drain state machine with registered line, valid and count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         line_q    <= '0;
         out_vld_q <= 1'b0;
         out_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE, FILL: begin
               if (w_xfer) begin
                  line_q <= line_d;
                  if (w_close) begin
                     state_q   <= FULL;
                     out_vld_q <= 1'b1;
                     out_cnt_q <= {1'b0, idx_q} + (IDX_W+1)'(1);
                  end else begin
                     state_q <= FILL;
                     idx_q   <= idx_q + IDX_W'(1);
                  end
               end
            end
            FULL: begin
               if (out_rdy) begin
                  state_q   <= IDLE;
                  idx_q     <= '0;
                  line_q    <= '0;
                  out_vld_q <= 1'b0;
                  out_cnt_q <= '0;
               end
            end
            default: begin
               state_q   <= IDLE;
               idx_q     <= '0;
               line_q    <= '0;
               out_vld_q <= 1'b0;
               out_cnt_q <= '0;
            end
         endcase
      end
   end

   assign out_vld  = out_vld_q;
   assign out_data = line_q;
   assign out_cnt  = out_cnt_q;

`ifdef RESP_PACK_STALL_CNT_EN
   logic [15:0] stall_q;

   // Count consumer back-pressure cycles, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (out_vld_q && !out_rdy && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire
